ma_stage: RTL and testbench

- Memory-access stage of the TinyRISC pipeline; sits between the EX/MA latch and the register-writeback stage.
- Issues load/store requests to data memory over a level request/acknowledge handshake.
- Stalls upstream while a memory access is outstanding.
- Registers aluResult, ldResult, prpc, control flags and register addresses into the MA/WB latch that drives writeback.

---
 rtl/tinyrisc_pkg.sv | 19 +
 rtl/ma_stage_mawb_latch.sv | 91 +++++++++
 rtl/ma_stage.sv | 224 ++++++++++++++++++++++
 tb/tb_ma_stage.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyrisc_pkg.sv
// Shared TinyRISC pipeline types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tinyrisc_pkg;

   // Datapath and register-file address widths.
   localparam int WORD_W = 32;
   localparam int REG_W  = 4;

   // Memory-access stage FSM states.
   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   // Load result reported when an access is abandoned by the watchdog.
   localparam logic [WORD_W-1:0] LD_ERR_VALUE = 32'hDEAD_BEEF;

endpackage : tinyrisc_pkg

// File: rtl/ma_stage_mawb_latch.sv
// MA/WB pipeline register: loads a completed instruction, otherwise inserts a bubble.
// Latency: 1 cycle from i_load to o_valid.
// Backpressure: none; writeback always accepts, so the latch never holds off.
import tinyrisc_pkg::*;

module mawb_latch #(
   parameter int W  = WORD_W,
   parameter int RW = REG_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_load,
   input  logic [W-1:0]  i_aluResult,
   input  logic [W-1:0]  i_ldResult,
   input  logic [W-1:0]  i_prpc,
   input  logic          i_isLd,
   input  logic          i_isCall,
   input  logic          i_isWb,
   input  logic [RW-1:0] i_ra,
   input  logic [RW-1:0] i_rd,
   input  logic          i_err,
   output logic          o_valid,
   output logic [W-1:0]  o_aluResult,
   output logic [W-1:0]  o_ldResult,
   output logic [W-1:0]  o_prpc,
   output logic          o_isLd,
   output logic          o_isCall,
   output logic          o_isWb,
   output logic [RW-1:0] o_ra,
   output logic [RW-1:0] o_rd,
   output logic          o_err
);

   logic          r_valid;
   logic          r_err;
   logic [W-1:0]  r_aluResult;
   logic [W-1:0]  r_ldResult;
   logic [W-1:0]  r_prpc;
   logic          r_isLd;
   logic          r_isCall;
   logic          r_isWb;
   logic [RW-1:0] r_ra;
   logic [RW-1:0] r_rd;

   // Valid and error follow the load enable every cycle, so a non-load cycle is a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_valid <= i_load;
         r_err   <= i_load & i_err;
      end
   end

   // Payload only changes when a completed instruction is loaded; bubbles keep old data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_aluResult <= '0;
         r_ldResult  <= '0;
         r_prpc      <= '0;
         r_isLd      <= 1'b0;
         r_isCall    <= 1'b0;
         r_isWb      <= 1'b0;
         r_ra        <= '0;
         r_rd        <= '0;
      end else if (i_load) begin
         r_aluResult <= i_aluResult;
         r_ldResult  <= i_ldResult;
         r_prpc      <= i_prpc;
         r_isLd      <= i_isLd;
         r_isCall    <= i_isCall;
         r_isWb      <= i_isWb;
         r_ra        <= i_ra;
         r_rd        <= i_rd;
      end
   end

   assign o_valid     = r_valid;
   assign o_err       = r_err;
   assign o_aluResult = r_aluResult;
   assign o_ldResult  = r_ldResult;
   assign o_prpc      = r_prpc;
   assign o_isLd      = r_isLd;
   assign o_isCall    = r_isCall;
   // A stale register write must never leak out of a bubble cycle.
   assign o_isWb      = r_isWb & r_valid;
   assign o_ra        = r_ra;
   assign o_rd        = r_rd;

endmodule : mawb_latch

// File: rtl/ma_stage.sv
// TinyRISC memory-access stage: issues ld/st over a level req/ack handshake, feeds MA/WB latch.
// Latency: non-memory op 1 cycle; memory op 1 + cycles until mem_ack.
// Backpressure: ma_stall holds the EX/MA latch while an access is outstanding.
// Optional watchdog abort enabled by defining MA_TIMEOUT_EN.
import tinyrisc_pkg::*;

module ma_stage #(
   parameter int W       = WORD_W,
   parameter int RW      = REG_W,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [W-1:0]  in_aluResult,
   input  logic [W-1:0]  in_op2,
   input  logic [W-1:0]  in_pc,
   input  logic          in_isLd,
   input  logic          in_isSt,
   input  logic          in_isCall,
   input  logic          in_isWb,
   input  logic [RW-1:0] in_ra,
   input  logic [RW-1:0] in_rd,
   output logic          ma_stall,
   output logic          mem_req,
   output logic          mem_we,
   output logic [W-1:0]  mem_addr,
   output logic [W-1:0]  mem_wdata,
   input  logic          mem_ack,
   input  logic [W-1:0]  mem_rdata,
   output logic          wb_valid,
   output logic [W-1:0]  aluResult,
   output logic [W-1:0]  ldResult,
   output logic [W-1:0]  prpc,
   output logic          isLd,
   output logic          isCall,
   output logic          isWb,
   output logic [RW-1:0] ra,
   output logic [RW-1:0] rd,
   output logic          mem_err
);

   state_t        r_state;
   state_t        w_next_state;

   // Request captured on issue so WAIT is independent of the upstream latch.
   logic [W-1:0]  r_addr;
   logic [W-1:0]  r_wdata;
   logic          r_we;
   logic          r_isLd;
   logic [W-1:0]  r_pc;
   logic          r_isCall;
   logic          r_isWb;
   logic [RW-1:0] r_ra;
   logic [RW-1:0] r_rd;

   logic          w_mem_op;
   logic          w_timeout;
   logic          w_complete;
   logic [W-1:0]  w_aluResult;
   logic [W-1:0]  w_ldResult;
   logic [W-1:0]  w_prpc;
   logic          w_isLd;
   logic          w_isCall;
   logic          w_isWb;
   logic [RW-1:0] w_ra;
   logic [RW-1:0] w_rd;
   logic          w_err;

   // Load takes priority when both flags are set.
   assign w_mem_op = in_valid & (in_isLd | in_isSt);

`ifdef MA_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] r_wdog;

   // Watchdog counts WAIT cycles and restarts from zero on every entry to WAIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wdog <= '0;
      end else if (r_state == WAIT) begin
         r_wdog <= r_wdog + CW'(1);
      end else begin
         r_wdog <= '0;
      end
   end

   // Fires on the TIMEOUT-th WAIT cycle; a late ack in that same cycle still wins.
   assign w_timeout = (r_state == WAIT) && !mem_ack && (r_wdog == CW'(TIMEOUT - 1));
`else
   assign w_timeout = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state: only an un-acked issue enters WAIT; ack or watchdog leaves it.
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         IDLE: if (w_mem_op && !mem_ack) w_next_state = WAIT;
         WAIT: if (mem_ack || w_timeout) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // FSM outputs: memory interface, stall, and the instruction offered to the MA/WB latch.
   always_comb begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = in_aluResult;
      mem_wdata   = in_op2;
      ma_stall    = 1'b0;
      w_complete  = 1'b0;
      w_aluResult = in_aluResult;
      w_ldResult  = '0;
      w_prpc      = in_pc;
      w_isLd      = in_isLd;
      w_isCall    = in_isCall;
      w_isWb      = in_isWb;
      w_ra        = in_ra;
      w_rd        = in_rd;
      w_err       = 1'b0;
      unique case (r_state)
         IDLE: begin
            mem_req    = w_mem_op;
            mem_we     = w_mem_op & in_isSt & ~in_isLd;
            ma_stall   = w_mem_op & ~mem_ack;
            w_complete = in_valid & (~w_mem_op | mem_ack);
            if (in_isLd) w_ldResult = mem_rdata;
         end
         WAIT: begin
            mem_req     = 1'b1;
            mem_we      = r_we;
            mem_addr    = r_addr;
            mem_wdata   = r_wdata;
            ma_stall    = ~(mem_ack | w_timeout);
            w_complete  = mem_ack | w_timeout;
            w_aluResult = r_addr;
            w_prpc      = r_pc;
            w_isLd      = r_isLd;
            w_isCall    = r_isCall;
            w_isWb      = r_isWb & ~w_timeout;
            w_ra        = r_ra;
            w_rd        = r_rd;
            w_err       = w_timeout;
            if (w_timeout) begin
               w_ldResult = W'(LD_ERR_VALUE);
            end else if (r_isLd) begin
               w_ldResult = mem_rdata;
            end
         end
         default: begin
            mem_req = 1'b0;
         end
      endcase
      // Reset is asynchronous, so the handshake must drop without waiting for an edge.
      if (rst) begin
         mem_req    = 1'b0;
         ma_stall   = 1'b0;
         w_complete = 1'b0;
      end
   end

   // Capture the issuing instruction whenever a memory op is presented in IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr   <= '0;
         r_wdata  <= '0;
         r_we     <= 1'b0;
         r_isLd   <= 1'b0;
         r_pc     <= '0;
         r_isCall <= 1'b0;
         r_isWb   <= 1'b0;
         r_ra     <= '0;
         r_rd     <= '0;
      end else if (r_state == IDLE && w_mem_op) begin
         r_addr   <= in_aluResult;
         r_wdata  <= in_op2;
         r_we     <= in_isSt & ~in_isLd;
         r_isLd   <= in_isLd;
         r_pc     <= in_pc;
         r_isCall <= in_isCall;
         r_isWb   <= in_isWb;
         r_ra     <= in_ra;
         r_rd     <= in_rd;
      end
   end

   mawb_latch #(
      .W  (W),
      .RW (RW)
   ) u_mawb_latch (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_complete),
      .i_aluResult (w_aluResult),
      .i_ldResult  (w_ldResult),
      .i_prpc      (w_prpc),
      .i_isLd      (w_isLd),
      .i_isCall    (w_isCall),
      .i_isWb      (w_isWb),
      .i_ra        (w_ra),
      .i_rd        (w_rd),
      .i_err       (w_err),
      .o_valid     (wb_valid),
      .o_aluResult (aluResult),
      .o_ldResult  (ldResult),
      .o_prpc      (prpc),
      .o_isLd      (isLd),
      .o_isCall    (isCall),
      .o_isWb      (isWb),
      .o_ra        (ra),
      .o_rd        (rd),
      .o_err       (mem_err)
   );

endmodule : ma_stage

// File: tb/tb_ma_stage.sv
// Self-checking bench for ma_stage: scoreboard of expected writebacks plus per-scenario checks.
// Latency: n/a.
// Backpressure: bench holds upstream inputs while ma_stall is high.
module tb_ma_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_aluResult, in_op2, in_pc;
   logic        in_isLd, in_isSt, in_isCall, in_isWb;
   logic [3:0]  in_ra, in_rd;
   logic        ma_stall, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic [31:0] aluResult, ldResult, prpc;
   logic        isLd, isCall, isWb;
   logic [3:0]  ra, rd;
   logic        mem_err;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] ld;
      logic [31:0] pc;
      logic        is_ld;
      logic        is_call;
      logic        is_wb;
      logic [3:0]  ra;
      logic [3:0]  rd;
      logic        err;
   } wb_t;

   wb_t exp_q[$];
   wb_t mon_act;
   wb_t mon_exp;
   int  checks   = 0;
   int  failures = 0;

   ma_stage #(.W(32), .RW(4), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_aluResult(in_aluResult),
      .in_op2(in_op2), .in_pc(in_pc), .in_isLd(in_isLd), .in_isSt(in_isSt),
      .in_isCall(in_isCall), .in_isWb(in_isWb), .in_ra(in_ra), .in_rd(in_rd),
      .ma_stall(ma_stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .aluResult(aluResult), .ldResult(ldResult), .prpc(prpc),
      .isLd(isLd), .isCall(isCall), .isWb(isWb), .ra(ra), .rd(rd), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   // Scoreboard: every writeback seen must match the oldest expected entry.
   always @(negedge clk) begin
      if (wb_valid === 1'b1) begin
         mon_act = '{aluResult, ldResult, prpc, isLd, isCall, isWb, ra, rd, mem_err};
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL wb_unexpected: got writeback %h, expected none", mon_act);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_act !== mon_exp) begin
               failures++;
               $display("FAIL wb_data: got %h, expected %h", mon_act, mon_exp);
            end
         end
      end
   end

   task automatic drive_idle();
      in_valid = 1'b0; in_aluResult = '0; in_op2 = '0; in_pc = '0;
      in_isLd = 1'b0; in_isSt = 1'b0; in_isCall = 1'b0; in_isWb = 1'b0;
      in_ra = '0; in_rd = '0; mem_ack = 1'b0; mem_rdata = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_idle();
      in_valid = 1'b1; in_isLd = 1'b1; in_aluResult = 32'h44;
      repeat (2) @(negedge clk);
      checks++; if (mem_req !== 1'b0)  begin failures++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
      checks++; if (ma_stall !== 1'b0) begin failures++; $display("FAIL rst_stall: got %b want 0", ma_stall); end
      checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid); end
      checks++; if ({aluResult, ldResult, prpc} !== 96'h0) begin failures++; $display("FAIL rst_data: got %h %h %h want 0", aluResult, ldResult, prpc); end
      checks++; if ({isLd, isCall, isWb, ra, rd, mem_err} !== 12'h0) begin failures++; $display("FAIL rst_flags: got %b%b%b %h %h %b want 0", isLd, isCall, isWb, ra, rd, mem_err); end
      @(posedge clk); #1;
      drive_idle();
      rst = 1'b0;
   endtask

   task automatic test_alu();
      @(posedge clk); #1;
      in_valid = 1'b1; in_isWb = 1'b1; in_aluResult = 32'h1234; in_rd = 4'd3; in_pc = 32'h10;
      exp_q.push_back('{32'h1234, 32'h0, 32'h10, 1'b0, 1'b0, 1'b1, 4'd0, 4'd3, 1'b0});
      @(negedge clk);
      checks++; if (ma_stall !== 1'b0) begin failures++; $display("FAIL alu_stall: got %b want 0", ma_stall); end
      checks++; if (mem_req !== 1'b0)  begin failures++; $display("FAIL alu_mem_req: got %b want 0", mem_req); end
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL alu_latency: got wb_valid=%b want 1", wb_valid); end
   endtask

   task automatic test_zero_wait_load();
      @(posedge clk); #1;
      in_valid = 1'b1; in_isLd = 1'b1; in_isWb = 1'b1; in_aluResult = 32'h40; in_op2 = 32'h77;
      in_pc = 32'h20; in_rd = 4'd5; mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
      exp_q.push_back('{32'h40, 32'hCAFE_0001, 32'h20, 1'b1, 1'b0, 1'b1, 4'd0, 4'd5, 1'b0});
      @(negedge clk);
      checks++; if (mem_req !== 1'b1)     begin failures++; $display("FAIL zw_mem_req: got %b want 1", mem_req); end
      checks++; if (mem_addr !== 32'h40)  begin failures++; $display("FAIL zw_addr: got %h want 40", mem_addr); end
      checks++; if (mem_we !== 1'b0)      begin failures++; $display("FAIL zw_we: got %b want 0", mem_we); end
      checks++; if (ma_stall !== 1'b0)    begin failures++; $display("FAIL zw_stall: got %b want 0", ma_stall); end
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      checks++; if (mem_req !== 1'b0)  begin failures++; $display("FAIL zw_req_drop: got %b want 0", mem_req); end
      checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL zw_latency: got wb_valid=%b want 1", wb_valid); end
   endtask

   task automatic test_store_wait();
      @(posedge clk); #1;
      in_valid = 1'b1; in_isSt = 1'b1; in_aluResult = 32'h80; in_op2 = 32'h55; in_pc = 32'h30; in_rd = 4'd7;
      exp_q.push_back('{32'h80, 32'h0, 32'h30, 1'b0, 1'b0, 1'b0, 4'd0, 4'd7, 1'b0});
      for (int c = 0; c < 4; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
            in_aluResult = 32'hBAD; in_op2 = 32'hBAD;
            mem_ack = (c == 3);
         end
         @(negedge clk);
         checks++; if ({mem_req, mem_we} !== 2'b11) begin failures++; $display("FAIL st_req_we c%0d: got %b%b want 11", c, mem_req, mem_we); end
         checks++; if ({mem_addr, mem_wdata} !== {32'h80, 32'h55}) begin failures++; $display("FAIL st_addr_data c%0d: got %h %h want 80 55", c, mem_addr, mem_wdata); end
         checks++; if (ma_stall !== (c != 3)) begin failures++; $display("FAIL st_stall c%0d: got %b want %b", c, ma_stall, (c != 3)); end
         checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL st_bubble c%0d: got wb_valid=%b want 0", c, wb_valid); end
      end
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL st_done: got wb_valid=%b want 1", wb_valid); end
   endtask

   task automatic test_call();
      @(posedge clk); #1;
      in_valid = 1'b1; in_isCall = 1'b1; in_isWb = 1'b1; in_pc = 32'h100; in_ra = 4'd15;
      in_rd = 4'd15; in_aluResult = 32'h104;
      exp_q.push_back('{32'h104, 32'h0, 32'h100, 1'b0, 1'b1, 1'b1, 4'd15, 4'd15, 1'b0});
      @(negedge clk);
      checks++; if (ma_stall !== 1'b0) begin failures++; $display("FAIL call_stall: got %b want 0", ma_stall); end
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL call_latency: got wb_valid=%b want 1", wb_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, p;
      logic [3:0]  r;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         a = $urandom; p = $urandom; r = 4'($urandom_range(0, 15));
         in_valid = 1'b1; in_aluResult = a; in_pc = p; in_rd = r; in_isWb = (i % 2 == 0);
         exp_q.push_back('{a, 32'h0, p, 1'b0, 1'b0, (i % 2 == 0), 4'd0, r, 1'b0});
         @(negedge clk);
         checks++; if (ma_stall !== 1'b0) begin failures++; $display("FAIL b2b_stall i%0d: got %b want 0", i, ma_stall); end
      end
      // Both ld and st flags: must behave as a load.
      @(posedge clk); #1;
      drive_idle();
      in_valid = 1'b1; in_isLd = 1'b1; in_isSt = 1'b1; in_isWb = 1'b1;
      in_aluResult = 32'h44; in_op2 = 32'h99; in_pc = 32'h50; in_rd = 4'd2;
      exp_q.push_back('{32'h44, 32'h1234_5678, 32'h50, 1'b1, 1'b0, 1'b1, 4'd0, 4'd2, 1'b0});
      @(negedge clk);
      checks++; if ({mem_req, mem_we, ma_stall} !== 3'b101) begin failures++; $display("FAIL ldst_issue: got req/we/stall=%b%b%b want 101", mem_req, mem_we, ma_stall); end
      @(posedge clk); #1;
      mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      @(negedge clk);
      checks++; if (ma_stall !== 1'b0) begin failures++; $display("FAIL ldst_ack_stall: got %b want 0", ma_stall); end
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL ldst_done: got wb_valid=%b want 1", wb_valid); end
      // Stray ack with no request outstanding must not create a writeback.
      @(posedge clk); #1;
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL stray_req: got %b want 0", mem_req); end
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL stray_ack: got wb_valid=%b want 0", wb_valid); end
   endtask

   task automatic test_reset_mid_wait();
      @(posedge clk); #1;
      in_valid = 1'b1; in_isLd = 1'b1; in_isWb = 1'b1; in_aluResult = 32'h60; in_rd = 4'd4;
      @(negedge clk);
      checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rmw_issue: got %b want 1", mem_req); end
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      checks++; if ({mem_req, ma_stall} !== 2'b11) begin failures++; $display("FAIL rmw_wait: got req/stall=%b%b want 11", mem_req, ma_stall); end
      #1 rst = 1'b1;
      #1;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rmw_req_drop: got %b want 0", mem_req); end
      checks++; if ({ma_stall, wb_valid} !== 2'b00) begin failures++; $display("FAIL rmw_state: got stall/wb=%b%b want 00", ma_stall, wb_valid); end
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b1; in_isWb = 1'b1; in_aluResult = 32'hABC; in_pc = 32'h70; in_rd = 4'd9;
      exp_q.push_back('{32'hABC, 32'h0, 32'h70, 1'b0, 1'b0, 1'b1, 4'd0, 4'd9, 1'b0});
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL rmw_recover: got wb_valid=%b want 1", wb_valid); end
   endtask

   task automatic test_watchdog();
      @(posedge clk); #1;
      in_valid = 1'b1; in_isLd = 1'b1; in_isWb = 1'b1; in_aluResult = 32'h90; in_pc = 32'h80; in_rd = 4'd6;
`ifdef MA_TIMEOUT_EN
      exp_q.push_back('{32'h90, 32'hDEAD_BEEF, 32'h80, 1'b1, 1'b0, 1'b0, 4'd0, 4'd6, 1'b1});
      for (int c = 1; c <= 16; c++) begin
         @(posedge clk); #1;
         drive_idle();
         @(negedge clk);
         checks++; if ({mem_req, ma_stall} !== {1'b1, (c != 16)}) begin failures++; $display("FAIL wd_wait c%0d: got req/stall=%b%b want 1%b", c, mem_req, ma_stall, (c != 16)); end
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if ({wb_valid, mem_err, mem_req, isWb} !== 4'b1100) begin failures++; $display("FAIL wd_abort: got wb/err/req/isWb=%b%b%b%b want 1100", wb_valid, mem_err, mem_req, isWb); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL wd_err_pulse: got %b want 0", mem_err); end
`else
      repeat (40) begin
         @(posedge clk); #1;
         drive_idle();
      end
      @(negedge clk);
      checks++; if ({mem_req, ma_stall, wb_valid, mem_err} !== 4'b1100) begin failures++; $display("FAIL long_wait: got req/stall/wb/err=%b%b%b%b want 1100", mem_req, ma_stall, wb_valid, mem_err); end
      checks++; if (mem_addr !== 32'h90) begin failures++; $display("FAIL long_wait_addr: got %h want 90", mem_addr); end
      @(posedge clk); #1;
      mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
      exp_q.push_back('{32'h90, 32'h0BAD_F00D, 32'h80, 1'b1, 1'b0, 1'b1, 4'd0, 4'd6, 1'b0});
      @(negedge clk);
      checks++; if (ma_stall !== 1'b0) begin failures++; $display("FAIL long_ack_stall: got %b want 0", ma_stall); end
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      checks++; if ({wb_valid, mem_err} !== 2'b10) begin failures++; $display("FAIL long_done: got wb/err=%b%b want 10", wb_valid, mem_err); end
`endif
   endtask

   initial begin
      test_reset();
      test_alu();
      test_zero_wait_load();
      test_store_wait();
      test_call();
      test_back_to_back();
      test_reset_mid_wait();
      test_watchdog();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL wb_missing: got %0d outstanding expected writebacks, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_ma_stage
